// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal_op, mem_err, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal_op, mem_err, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory ready handshake and wait timeout.
// Define MC_BNE_EN to add the bne instruction (BNEEX state, encoding 12).
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic              clk,
  input logic              reset_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
`ifdef MC_BNE_EN
    , StBneEx = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam bit             TimeoutEn  = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W:0] TimeoutLim = (CNT_W + 1)'(MEM_TIMEOUT);

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_mem_req;
  logic             w_wait;
  logic             w_timeout;
  logic             w_illegal;
  logic             w_rtype_ok;
  logic [2:0]       w_rtype_alu;

  always_comb begin
    w_rtype_ok  = 1'b1;
    w_rtype_alu = 3'b010;
    case (bus.funct)
      6'b100000: w_rtype_alu = 3'b010;
      6'b100010: w_rtype_alu = 3'b110;
      6'b100100: w_rtype_alu = 3'b000;
      6'b100101: w_rtype_alu = 3'b001;
      6'b101010: w_rtype_alu = 3'b111;
      default:   w_rtype_ok  = 1'b0;
    endcase
  end

  assign w_mem_req = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_wait    = w_mem_req && !bus.mem_ready;
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  // The limit is hit on the wait cycle that would bring the count to MEM_TIMEOUT.
  assign w_timeout = TimeoutEn && w_wait && (w_cnt_inc == TimeoutLim);

  always_comb begin
    w_state_d = r_state;
    w_illegal = 1'b0;
    unique case (r_state)
      StFetch: begin
        if (bus.mem_ready)  w_state_d = StDecode;
        else if (w_timeout) w_state_d = StFetch;
      end
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: w_state_d = StMemAdr;
          OpRtype: begin
            w_state_d = w_rtype_ok ? StRtypeEx : StFetch;
            w_illegal = !w_rtype_ok;
          end
          OpBeq:  w_state_d = StBeqEx;
          OpAddi: w_state_d = StAddiEx;
          OpJ:    w_state_d = StJEx;
`ifdef MC_BNE_EN
          OpBne:  w_state_d = StBneEx;
`endif
          default: begin
            w_state_d = StFetch;
            w_illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: w_state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (bus.mem_ready)  w_state_d = StMemWb;
        else if (w_timeout) w_state_d = StFetch;
      end
      StMemWr: begin
        if (bus.mem_ready || w_timeout) w_state_d = StFetch;
      end
      StRtypeEx: w_state_d = StRtypeWb;
      StAddiEx:  w_state_d = StAddiWb;
      default:   w_state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StFetch;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      // Clearing on any state change covers entry to FETCH/MEMRD/MEMWR.
      if (w_timeout || (w_state_d != r_state)) r_cnt <= '0;
      else if (w_wait && !(&r_cnt))            r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.pcen       = 1'b0;
    bus.alucontrol = 3'b000;
    bus.illegal_op = 1'b0;
    bus.mem_err    = 1'b0;
    bus.state      = r_state;
    if (reset_n) begin
      bus.mem_err = w_timeout;
      unique case (r_state)
        StFetch: begin
          bus.mem_req    = 1'b1;
          bus.alusrcb    = 2'b01;
          bus.alucontrol = 3'b010;
          bus.irwrite    = bus.mem_ready;
          bus.pcen       = bus.mem_ready;
        end
        StDecode: begin
          bus.alusrcb    = 2'b11;
          bus.alucontrol = 3'b010;
          bus.illegal_op = w_illegal;
        end
        StMemAdr, StAddiEx: begin
          bus.alusrca    = 1'b1;
          bus.alusrcb    = 2'b10;
          bus.alucontrol = 3'b010;
        end
        StMemRd: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        StMemWb: begin
          bus.memtoreg = 1'b1;
          bus.regwrite = 1'b1;
        end
        StMemWr: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = bus.mem_ready;
        end
        StRtypeEx: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = w_rtype_alu;
        end
        StRtypeWb: begin
          bus.regdst   = 1'b1;
          bus.regwrite = 1'b1;
        end
        StBeqEx: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = 3'b110;
          bus.pcsrc      = 2'b01;
          bus.pcen       = bus.zero;
        end
`ifdef MC_BNE_EN
        StBneEx: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = 3'b110;
          bus.pcsrc      = 2'b01;
          bus.pcen       = !bus.zero;
        end
`endif
        StAddiWb: bus.regwrite = 1'b1;
        StJEx: begin
          bus.pcsrc = 2'b10;
          bus.pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expectations queued by the driver,
// compared on the falling edge.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state;
  } out_t;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4;
  localparam logic [3:0] SMW = 4'd5, SRE = 4'd6, SRW = 4'd7, SBEQ = 4'd8, SAE = 4'd9;
  localparam logic [3:0] SAW = 4'd10, SJ = 4'd11, SBNE = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cyc    = 0;
  out_t q_exp[$];
  logic [3:0] q_st[$];

  mc_control_fsm_if bus ();

  mc_control_fsm #(
    .MEM_TIMEOUT(4),
    .CNT_W      (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic out_t pack_out();
    out_t o;
    o = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
         bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol,
         bus.illegal_op, bus.mem_err, bus.state};
    return o;
  endfunction

  // Reference decode of the expected outputs for one cycle.
  function automatic out_t ref_out(input logic [3:0] st, input logic rdy, input logic z,
                                   input logic tmo, input logic ill, input logic [2:0] aluc);
    out_t o;
    o = '0;
    o.state   = st;
    o.mem_err = tmo;
    case (st)
      SF:   begin o.mem_req = 1; o.alusrcb = 2'b01; o.alucontrol = 3'b010;
                  o.irwrite = rdy; o.pcen = rdy; end
      SD:   begin o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal_op = ill; end
      SMA, SAE: begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      SMR:  begin o.mem_req = 1; o.iord = 1; end
      SMWB: begin o.memtoreg = 1; o.regwrite = 1; end
      SMW:  begin o.mem_req = 1; o.iord = 1; o.memwrite = rdy; end
      SRE:  begin o.alusrca = 1; o.alucontrol = aluc; end
      SRW:  begin o.regdst = 1; o.regwrite = 1; end
      SBEQ: begin o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      SBNE: begin o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = !z; end
      SAW:  o.regwrite = 1;
      SJ:   begin o.pcsrc = 2'b10; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic rnd();
    return $urandom_range(0, 1) != 0;
  endfunction

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      out_t e;
      logic [3:0] s;
      e = q_exp.pop_front();
      s = q_st.pop_front();
      check_eq($sformatf("cyc%0d_st%0d", n_cyc, s), 32'(pack_out()), 32'(e));
    end
  end

  // Called at posedge+1: drive one cycle of inputs and queue its expected outputs.
  task automatic cyc(input logic rdy, input logic z, input logic [3:0] st, input logic tmo,
                     input logic ill, input logic [2:0] aluc);
    bus.mem_ready = rdy;
    bus.zero      = z;
    q_exp.push_back(ref_out(st, rdy, z, tmo, ill, aluc));
    q_st.push_back(st);
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    bus.op    = o;
    bus.funct = f;
  endtask

  task automatic do_fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(1'b0, rnd(), SF, 1'b0, 1'b0, 3'b0);
    cyc(1'b1, rnd(), SF, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic do_lw(input int waits);
    set_instr(OP_LW, 6'h00);
    do_fetch(0);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SMA, 1'b0, 1'b0, 3'b0);
    for (int i = 0; i < waits; i++) cyc(1'b0, rnd(), SMR, 1'b0, 1'b0, 3'b0);
    cyc(1'b1, rnd(), SMR, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SMWB, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic do_sw(input int waits);
    set_instr(OP_SW, 6'h00);
    do_fetch(0);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SMA, 1'b0, 1'b0, 3'b0);
    for (int i = 0; i < waits; i++) cyc(1'b0, rnd(), SMW, 1'b0, 1'b0, 3'b0);
    cyc(1'b1, rnd(), SMW, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic do_rtype(input logic [5:0] f, input logic [2:0] aluc);
    set_instr(OP_R, f);
    do_fetch(0);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SRE, 1'b0, 1'b0, aluc);
    cyc(rnd(), rnd(), SRW, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic do_beq(input logic z);
    set_instr(OP_BEQ, 6'h2a);
    do_fetch(0);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), z, SBEQ, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic do_illegal(input logic [5:0] o, input logic [5:0] f);
    set_instr(o, f);
    do_fetch(0);
    cyc(rnd(), 1'b0, SD, 1'b0, 1'b1, 3'b0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.op        = OP_LW;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", 32'(pack_out()), 32'h0);
    check_eq("rst_state", 32'(bus.state), 32'(SF));
    reset_n = 1'b1;

    do_lw(0);
    do_sw(3);
    do_rtype(6'b100010, 3'b110);
    do_rtype(6'b100000, 3'b010);
    do_rtype(6'b100100, 3'b000);
    do_rtype(6'b100101, 3'b001);
    do_rtype(6'b101010, 3'b111);
    do_beq(1'b1);
    do_beq(1'b0);

    set_instr(OP_ADDI, 6'h00);
    do_fetch(2);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SAE, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SAW, 1'b0, 1'b0, 3'b0);

    // Fetch timeout on the 4th wait cycle, then retry completing on the limit cycle.
    set_instr(OP_J, 6'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, SF, 1'b0, 1'b0, 3'b0);
    cyc(1'b0, 1'b0, SF, 1'b1, 1'b0, 3'b0);
    do_fetch(3);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SJ, 1'b0, 1'b0, 3'b0);

    // Load data-read timeout.
    set_instr(OP_LW, 6'h00);
    do_fetch(0);
    cyc(rnd(), 1'b0, SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), 1'b0, SMA, 1'b0, 1'b0, 3'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, SMR, 1'b0, 1'b0, 3'b0);
    cyc(1'b0, 1'b0, SMR, 1'b1, 1'b0, 3'b0);

    // Store write timeout: no memwrite at all.
    set_instr(OP_SW, 6'h00);
    do_fetch(1);
    cyc(rnd(), 1'b0, SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), 1'b0, SMA, 1'b0, 1'b0, 3'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, SMW, 1'b0, 1'b0, 3'b0);
    cyc(1'b0, 1'b0, SMW, 1'b1, 1'b0, 3'b0);

    // bne opcode.
`ifdef MC_BNE_EN
    set_instr(OP_BNE, 6'h00);
    do_fetch(0);
    cyc(rnd(), 1'b0, SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), 1'b0, SBNE, 1'b0, 1'b0, 3'b0);
`else
    do_illegal(OP_BNE, 6'h00);
`endif
    do_illegal(6'b111111, 6'h20);
    do_illegal(OP_R, 6'b000000);
    do_lw(1);

    // Reset in the middle of a store wait: no write strobe even with mem_ready high.
    set_instr(OP_SW, 6'h00);
    do_fetch(0);
    cyc(rnd(), 1'b0, SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), 1'b0, SMA, 1'b0, 1'b0, 3'b0);
    cyc(1'b0, 1'b0, SMW, 1'b0, 1'b0, 3'b0);
    bus.mem_ready = 1'b1;
    reset_n       = 1'b0;
    #1;
    check_eq("midrst_outs", 32'(pack_out()), 32'h0);
    @(posedge clk);
    #1;
    check_eq("midrst_state", 32'(bus.state), 32'(SF));
    reset_n = 1'b1;
    do_rtype(6'b100000, 3'b010);
    set_instr(OP_J, 6'h00);
    do_fetch(0);
    cyc(rnd(), rnd(), SD, 1'b0, 1'b0, 3'b0);
    cyc(rnd(), rnd(), SJ, 1'b0, 1'b0, 3'b0);
    do_fetch(0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control unit for the multicycle MIPS datapath built from the shared regfile, mux2/mux3/mux4, sl2, signext and flopen blocks.
- Sequences each instruction through FETCH/DECODE/execute/writeback states and drives every datapath select and enable.
- Supports a ready handshake so instruction/data memory may take several cycles, with a timeout counter.
- Covers lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting on mem_ready before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory access complete this cycle
- mem_req  output  1  memory access requested
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regdst  output  1  write register select: 0 = rt, 1 = rd
- memtoreg  output  1  writeback data select: 0 = ALUOut, 1 = Data
- regwrite  output  1  register file write enable (we3)
- alusrca  output  1  ALU A select: 0 = PC, 1 = A
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC register enable
- alucontrol  output  3  ALU operation code
- illegal_op  output  1  one-cycle pulse on an undecodable instruction
- mem_err  output  1  one-cycle pulse on memory timeout
- state  output  4  current state, for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX. Optional BNEEX (see Optional Feature).
- Reset: async, reset_n low forces state=FETCH and the wait counter to 0. All outputs are forced to 0 while reset_n is low; this overrides the FETCH decode. The first request is issued in the first cycle after release. Reset mid-wait abandons the access without any write strobe.
- Outputs are a Moore decode of state, except the qualifications below, which also depend on mem_ready/zero. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite and pcen are asserted only when mem_ready=1.
  - Advance to DECODE on mem_ready; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (precomputes the branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX; an unknown funct instead pulses illegal_op and goes to FETCH
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH with illegal_op pulse
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next is MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: mem_req=1, iord=1. memwrite is asserted only together with mem_ready. Hold until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol by funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - Next state RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen = zero. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcen=1, then FETCH.
- Cycle counts, with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - Each memory wait cycle adds 1.
- Timeout:
  - The counter clears on entry to FETCH/MEMRD/MEMWR and increments on each cycle with mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: mem_err pulses that cycle, the state goes to FETCH, and no irwrite/pcen/memwrite/regwrite is issued.
  - A fetch timeout retries the same PC.
  - mem_ready in the same cycle as the limit wins: a normal completion, no mem_err.
- mem_ready is ignored in states with mem_req=0.
- The counter saturates and never wraps.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - op 000101 in DECODE -> BNEEX.
  - BNEEX outputs are identical to BEQEX except pcen = ~zero. Then FETCH.
  - state encoding 12 = BNEEX.
- Undefined: op 000101 is illegal (illegal_op pulse, return to FETCH). The BNEEX state does not exist.

Test Plan:
- Reset and fetch: reset_n low with mem_ready=1 -> all outputs 0, state=FETCH. After release, cycle 1 shows mem_req=1, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- Load word, zero wait: op=100011 with mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB shows regwrite=1, memtoreg=1, regdst=0.
- Store with wait: op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite asserts only on the mem_ready cycle, exactly once. Total 7 cycles.
- R-type and branch: funct=100010 -> alucontrol=110 in RTYPEEX and regdst=1 in RTYPEWB. Then op=000100 with zero=1 -> pcen=1, pcsrc=01. Repeat with zero=0 -> pcen=0.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 in FETCH -> mem_err pulse on the 4th wait cycle, no irwrite or pcen, FETCH re-entered. mem_ready=1 on that exact cycle -> no mem_err, normal advance.
- Illegal and macro: op=000101 with zero=0 -> without MC_BNE_EN, illegal_op pulses in DECODE and the state returns to FETCH. With MC_BNE_EN, state 12 is reached with pcen=1.
